// File: rtl/rk05_sync_filter.sv
// rk05_sync_filter: multi-channel input conditioner for asynchronous RK05
// bus and drive-control lines. Each channel is synchronized through a
// STAGES-deep flop chain, then qualified by a glitch filter that requires
// FILTER consecutive EN-qualified samples differing from the current output
// before the output level changes. Q, RISE and FALL are all registered.
module rk05_sync_filter #(
  parameter int               WIDTH  = 8,
  parameter int               STAGES = 2,
  parameter int               FILTER = 4,
  parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b1}}
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  // Counter is wide enough to hold FILTER; in practice it never exceeds
  // FILTER-1 because reaching FILTER commits the new level instead.
  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  generate
    if (STAGES < 2 || STAGES > 4 || FILTER < 1 || FILTER > 255) begin : g_bad_param
      $error("rk05_sync_filter: STAGES must be 2..4 and FILTER must be 1..255");
    end
  endgenerate

  logic [WIDTH-1:0] sync_r [STAGES];
  logic [CW-1:0]    cnt_r  [WIDTH];
  logic [CW-1:0]    cnt_s  [WIDTH];
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] y_s;

  assign y_s = sync_r[STAGES-1];

  // Per-channel filter: clear on agreement, count EN-qualified disagreements,
  // commit the new level and emit an edge pulse when the count completes.
  always_comb begin
    q_s    = q_r;
    rise_s = {WIDTH{1'b0}};
    fall_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_s[i] = cnt_r[i];
      if (y_s[i] == q_r[i]) begin
        cnt_s[i] = CNT_ZERO;
      end else if (EN) begin
        if (cnt_r[i] == CNT_LAST) begin
          q_s[i]    = y_s[i];
          cnt_s[i]  = CNT_ZERO;
          rise_s[i] = y_s[i];
          fall_s[i] = ~y_s[i];
        end else begin
          cnt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_s[i] = cnt_r[i];
      end
    end
  end

  // Synchronizer chain: shifts every edge independent of EN; reset loads INIT.
  always_ff @(posedge C) begin
    if (R) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_r[k] <= INIT;
      end
    end else begin
      sync_r[0] <= D;
      for (int k = 1; k < STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Filter state and registered outputs; reset wins over any completing count
  // and never produces an edge pulse.
  always_ff @(posedge C) begin
    if (R) begin
      q_r    <= INIT;
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      q_r    <= q_s;
      rise_r <= rise_s;
      fall_r <= fall_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  assign Q    = q_r;
  assign RISE = rise_r;
  assign FALL = fall_r;

endmodule

// File: tb/tb_rk05_sync_filter.sv
// Self-checking bench for rk05_sync_filter (default parameters): directed
// scenarios with hand-derived expectations plus a randomized run, all
// compared every cycle against a behavioural reference model.
module tb_rk05_sync_filter;

  localparam int         W   = 8;
  localparam int         ST  = 2;
  localparam int         FI  = 4;
  localparam logic [7:0] INI = 8'hFF;

  logic       C = 1'b0;
  logic       R;
  logic       EN;
  logic [7:0] D;
  logic [7:0] Q;
  logic [7:0] RISE;
  logic [7:0] FALL;

  rk05_sync_filter #(.WIDTH(W), .STAGES(ST), .FILTER(FI), .INIT(INI)) dut (
    .C(C), .R(R), .EN(EN), .D(D), .Q(Q), .RISE(RISE), .FALL(FALL)
  );

  always #5 C = ~C;

  // Reference model: synchronizer as a plain delay queue, filter as a count
  // of qualified disagreeing samples since the last agreement.
  logic [7:0] hist[$];
  logic [7:0] q_m;
  logic [7:0] rise_m;
  logic [7:0] fall_m;
  int         run_m [W];

  int n_cmp = 0;
  int n_err = 0;
  int rise_edge;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [7:0] y;
    if (R) begin
      q_m    = INI;
      rise_m = 8'h00;
      fall_m = 8'h00;
      hist.delete();
      for (int k = 0; k < ST; k++) hist.push_back(INI);
      for (int i = 0; i < W; i++) run_m[i] = 0;
    end else begin
      y = hist.pop_front();
      hist.push_back(D);
      rise_m = 8'h00;
      fall_m = 8'h00;
      for (int i = 0; i < W; i++) begin
        if (y[i] == q_m[i]) begin
          run_m[i] = 0;
        end else if (EN) begin
          run_m[i] = run_m[i] + 1;
          if (run_m[i] == FI) begin
            q_m[i]    = y[i];
            run_m[i]  = 0;
            rise_m[i] = y[i];
            fall_m[i] = ~y[i];
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge C);
    model_edge();
    #1;
    check_eq("Q", {24'h0, Q}, {24'h0, q_m});
    check_eq("RISE", {24'h0, RISE}, {24'h0, rise_m});
    check_eq("FALL", {24'h0, FALL}, {24'h0, fall_m});
    check_eq("RISE_FALL_excl", {24'h0, RISE & FALL}, 32'h0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    R  = 1'b1;
    EN = 1'b0;
    D  = 8'h00;

    // Reset default: two reset cycles with D=00, then release with EN=1.
    ticks(2);
    check_eq("reset_Q", {24'h0, Q}, 32'hFF);
    check_eq("reset_RISE", {24'h0, RISE}, 32'h00);
    check_eq("reset_FALL", {24'h0, FALL}, 32'h00);
    R  = 1'b0;
    EN = 1'b1;
    ticks(2);
    check_eq("rel_hold_e2", {24'h0, Q}, 32'hFF);
    ticks(3);
    check_eq("rel_hold_e5", {24'h0, Q}, 32'hFF);
    tick();
    check_eq("rel_Q_e6", {24'h0, Q}, 32'h00);
    check_eq("rel_FALL_e6", {24'h0, FALL}, 32'hFF);
    check_eq("rel_RISE_e6", {24'h0, RISE}, 32'h00);
    tick();
    check_eq("rel_FALL_e7", {24'h0, FALL}, 32'h00);

    // Latency: D[3] 0->1 with EN=1, Q[3] updates at edge 6.
    D = 8'h08;
    ticks(5);
    check_eq("lat_Q_e5", {24'h0, Q}, 32'h00);
    tick();
    check_eq("lat_Q_e6", {24'h0, Q}, 32'h08);
    check_eq("lat_RISE_e6", {24'h0, RISE}, 32'h08);
    tick();
    check_eq("lat_RISE_e7", {24'h0, RISE}, 32'h00);

    // Glitch: 3-cycle pulse on D[0] must be rejected.
    D = 8'h09;
    ticks(3);
    D = 8'h08;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("glitch3_Q", {24'h0, Q}, 32'h08);
      check_eq("glitch3_pulses", {24'h0, RISE | FALL}, 32'h00);
    end

    // 4-cycle pulse: rises at edge 6, falls at edge 10.
    D = 8'h09;
    ticks(4);
    D = 8'h08;
    ticks(2);
    check_eq("pulse4_Q_e6", {24'h0, Q}, 32'h09);
    check_eq("pulse4_RISE_e6", {24'h0, RISE}, 32'h01);
    ticks(3);
    check_eq("pulse4_Q_e9", {24'h0, Q}, 32'h09);
    tick();
    check_eq("pulse4_Q_e10", {24'h0, Q}, 32'h08);
    check_eq("pulse4_FALL_e10", {24'h0, FALL}, 32'h01);
    ticks(4);

    // EN gating: EN on every 3rd cycle. y[1] is high from edge 3; strobes at
    // edges 3, 6, 9, 12 -> Q[1] rises at edge 12.
    D = 8'h0A;
    rise_edge = -1;
    for (int k = 0; k < 30; k++) begin
      EN = (k % 3 == 2) ? 1'b1 : 1'b0;
      tick();
      if (RISE[1] && rise_edge < 0) rise_edge = k + 1;
    end
    check_eq("en_gate_edge", rise_edge, 32'd12);
    EN = 1'b1;

    // Reset mid-count: settle at FF, then drop D[2]; R on the completing edge.
    D = 8'hFF;
    ticks(10);
    D = 8'hFB;
    ticks(5);
    R = 1'b1;
    tick();
    check_eq("rmid_Q", {24'h0, Q}, 32'hFF);
    check_eq("rmid_FALL", {24'h0, FALL}, 32'h00);
    R = 1'b0;
    ticks(5);
    check_eq("rmid_restart_e5", {24'h0, Q}, 32'hFF);
    tick();
    check_eq("rmid_restart_e6", {24'h0, Q}, 32'hFB);
    check_eq("rmid_restart_FALL", {24'h0, FALL}, 32'h04);

    // Simultaneous channels: 0F -> F0.
    D = 8'h0F;
    ticks(10);
    D = 8'hF0;
    ticks(5);
    check_eq("sim_Q_e5", {24'h0, Q}, 32'h0F);
    tick();
    check_eq("sim_Q_e6", {24'h0, Q}, 32'hF0);
    check_eq("sim_RISE_e6", {24'h0, RISE}, 32'hF0);
    check_eq("sim_FALL_e6", {24'h0, FALL}, 32'h0F);
    tick();
    check_eq("sim_pulses_e7", {24'h0, RISE | FALL}, 32'h00);

    // Randomized: sparse bit flips, mostly-on EN, occasional reset.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] flip;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(7) == 0);
      D  = D ^ flip;
      EN = ($urandom_range(9) < 8);
      R  = ($urandom_range(199) == 0);
      tick();
    end
    R = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
